// File: rtl/alu_issuer_if.sv
// Bundle of the instruction handshake, ALU drive/result, completion and debug-read
// signals shared between the issuer (slave) and whatever feeds it (master).
`timescale 1ns/1ps

interface alu_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [5:0]  alu_func;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_res;
    logic        done;
    logic [1:0]  done_rd;
    logic [7:0]  done_value;
    logic        err;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_res, dbg_addr,
        output in_ready, alu_func, alu_a, alu_b, done, done_rd, done_value, err, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_res, dbg_addr,
        input  in_ready, alu_func, alu_a, alu_b, done, done_rd, done_value, err, dbg_data
    );
endinterface

// File: rtl/alu_issuer.sv
// Issues one instruction at a time to an external combinational ALU, holds the
// operands for SETTLE cycles, then writes the sampled result into a 4x8 register file.
`timescale 1ns/1ps

module alu_issuer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    alu_issuer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, HOLD, WB} state_t;

    state_t      r_state;
    logic [7:0]  r_regs [4];
    logic [1:0]  r_rd;
    logic [3:0]  r_settleCnt;
    logic [5:0]  r_aluFunc;
    logic [7:0]  r_aluA;
    logic [7:0]  r_aluB;
    logic        r_done;
    logic [1:0]  r_doneRd;
    logic [7:0]  r_doneValue;
    logic        r_err;

    logic [5:0]  w_funct;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [1:0]  w_rt;
    logic        w_supported;
    logic        w_unused;

    assign w_funct  = bus.in_instr[15:10];
    assign w_rd     = bus.in_instr[9:8];
    assign w_rs     = bus.in_instr[7:6];
    assign w_rt     = bus.in_instr[5:4];
    assign w_unused = &{1'b0, bus.in_instr[3:0]};

    always_comb begin
        w_supported = 1'b0;
        case (w_funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: w_supported = 1'b1;
            default: w_supported = 1'b0;
        endcase
    end

    // Operands are captured at the handshake edge, so an rd that aliases rs/rt
    // naturally sees the pre-write value; the write itself only happens in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_settleCnt <= '0;
            r_aluFunc   <= '0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_done      <= 1'b0;
            r_doneRd    <= '0;
            r_doneValue <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_supported) begin
                            r_aluFunc   <= w_funct;
                            r_aluA      <= r_regs[w_rs];
                            r_aluB      <= r_regs[w_rt];
                            r_rd        <= w_rd;
                            r_settleCnt <= 4'(SETTLE - 1);
                            r_state     <= HOLD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_settleCnt == 4'd0) begin
                        r_done      <= 1'b1;
                        r_doneRd    <= r_rd;
                        r_doneValue <= bus.alu_res;
                        r_aluFunc   <= '0;
                        r_aluA      <= '0;
                        r_aluB      <= '0;
                        r_state     <= WB;
                    end else begin
                        r_settleCnt <= r_settleCnt - 4'd1;
                    end
                end
                WB: begin
                    r_regs[r_doneRd] <= r_doneValue;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.alu_func   = r_aluFunc;
    assign bus.alu_a      = r_aluA;
    assign bus.alu_b      = r_aluB;
    assign bus.done       = r_done;
    assign bus.done_rd    = r_doneRd;
    assign bus.done_value = r_doneValue;
    assign bus.err        = r_err;
    assign bus.dbg_data   = r_regs[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issuer.sv
// Directed test of alu_issuer: one instance with SETTLE=1 and one with SETTLE=3,
// each fed by a behavioural ALU that can be overridden to preload registers.
`timescale 1ns/1ps

module tb_alu_issuer;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    logic       clk = 1'b0;
    logic       rst1N;
    logic       rst3N;
    logic       ov1;
    logic       ov3;
    logic [7:0] ovVal1;
    logic [7:0] ovVal3;
    int         assertCount = 0;
    int         failCount   = 0;

    alu_issuer_if if1();
    alu_issuer_if if3();

    alu_issuer #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst1N), .bus(if1.slave));
    alu_issuer #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst3N), .bus(if3.slave));

    function automatic logic [7:0] aluModel(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [5:0] f, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        return {f, rd, rs, rt, 4'h0};
    endfunction

    assign if1.alu_res = ov1 ? ovVal1 : aluModel(if1.alu_func, if1.alu_a, if1.alu_b);
    assign if3.alu_res = ov3 ? ovVal3 : aluModel(if3.alu_func, if3.alu_a, if3.alu_b);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Handshake on dut1, then leave the bench in cycle T+1 with in_instr scrambled.
    task automatic applyStimulus(input logic [15:0] instr);
        if1.in_valid = 1'b1;
        if1.in_instr = instr;
        @(negedge clk);
        if1.in_valid = 1'b0;
        if1.in_instr = 16'hFFFF;
    endtask

    task automatic checkReg1(input string tag, input logic [1:0] addr, input logic [7:0] expected);
        if1.dbg_addr = addr;
        #1;
        checkOutput(tag, {24'h0, if1.dbg_data}, {24'h0, expected});
    endtask

    task automatic checkReg3(input string tag, input logic [1:0] addr, input logic [7:0] expected);
        if3.dbg_addr = addr;
        #1;
        checkOutput(tag, {24'h0, if3.dbg_data}, {24'h0, expected});
    endtask

    task automatic preload1(input logic [1:0] rd, input logic [7:0] val);
        ov1    = 1'b1;
        ovVal1 = val;
        applyStimulus(mk(F_ADD, rd, 2'd0, 2'd0));
        @(negedge clk);
        checkOutput("preload1 done_value", {24'h0, if1.done_value}, {24'h0, val});
        ov1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload3(input logic [1:0] rd, input logic [7:0] val);
        ov3    = 1'b1;
        ovVal3 = val;
        if3.in_valid = 1'b1;
        if3.in_instr = mk(F_ADD, rd, 2'd0, 2'd0);
        @(negedge clk);
        if3.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("preload3 done_value", {24'h0, if3.done_value}, {24'h0, val});
        ov3 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst1N = 1'b0;
        rst3N = 1'b0;
        ov1 = 1'b0; ov3 = 1'b0; ovVal1 = '0; ovVal3 = '0;
        if1.in_valid = 1'b0; if1.in_instr = '0; if1.dbg_addr = '0;
        if3.in_valid = 1'b0; if3.in_instr = '0; if3.dbg_addr = '0;
        repeat (2) @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            checkReg1("reset dbg_data", 2'(i), 8'h00);
        end
        checkOutput("reset in_ready", {31'h0, if1.in_ready}, 32'h1);
        checkOutput("reset done", {31'h0, if1.done}, 32'h0);
        checkOutput("reset err", {31'h0, if1.err}, 32'h0);
        checkOutput("reset alu_func", {26'h0, if1.alu_func}, 32'h0);
        rst1N = 1'b1;
        rst3N = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", {31'h0, if1.in_ready}, 32'h1);

        // add rd=2 rs=1 rt=1 with R1=05
        preload1(2'd1, 8'h05);
        applyStimulus(mk(F_ADD, 2'd2, 2'd1, 2'd1));
        checkOutput("add alu_func", {26'h0, if1.alu_func}, 32'h20);
        checkOutput("add alu_a", {24'h0, if1.alu_a}, 32'h05);
        checkOutput("add alu_b", {24'h0, if1.alu_b}, 32'h05);
        checkOutput("add in_ready hold", {31'h0, if1.in_ready}, 32'h0);
        checkOutput("add done early", {31'h0, if1.done}, 32'h0);
        @(negedge clk);
        checkOutput("add done", {31'h0, if1.done}, 32'h1);
        checkOutput("add done_rd", {30'h0, if1.done_rd}, 32'h2);
        checkOutput("add done_value", {24'h0, if1.done_value}, 32'h0A);
        checkOutput("add alu_func after", {26'h0, if1.alu_func}, 32'h0);
        @(negedge clk);
        checkOutput("add done cleared", {31'h0, if1.done}, 32'h0);
        checkOutput("add in_ready back", {31'h0, if1.in_ready}, 32'h1);
        checkReg1("add R2", 2'd2, 8'h0A);

        // Unsupported funct
        applyStimulus(mk(6'b000000, 2'd3, 2'd1, 2'd2));
        checkOutput("bad err", {31'h0, if1.err}, 32'h1);
        checkOutput("bad done", {31'h0, if1.done}, 32'h0);
        checkOutput("bad alu_func", {26'h0, if1.alu_func}, 32'h0);
        checkOutput("bad alu_a", {24'h0, if1.alu_a}, 32'h0);
        checkOutput("bad in_ready", {31'h0, if1.in_ready}, 32'h1);
        @(negedge clk);
        checkOutput("bad err cleared", {31'h0, if1.err}, 32'h0);
        checkOutput("bad done later", {31'h0, if1.done}, 32'h0);
        checkReg1("bad R1", 2'd1, 8'h05);
        checkReg1("bad R2", 2'd2, 8'h0A);
        checkReg1("bad R3", 2'd3, 8'h00);

        // Wrap-around with rd aliasing rs
        preload1(2'd1, 8'hFF);
        preload1(2'd2, 8'h01);
        applyStimulus(mk(F_ADD, 2'd1, 2'd1, 2'd2));
        checkOutput("wrap alu_a", {24'h0, if1.alu_a}, 32'hFF);
        checkOutput("wrap alu_b", {24'h0, if1.alu_b}, 32'h01);
        @(negedge clk);
        checkOutput("wrap done", {31'h0, if1.done}, 32'h1);
        checkOutput("wrap done_rd", {30'h0, if1.done_rd}, 32'h1);
        checkOutput("wrap done_value", {24'h0, if1.done_value}, 32'h00);
        @(negedge clk);
        checkReg1("wrap R1", 2'd1, 8'h00);
        checkReg1("wrap R2", 2'd2, 8'h01);

        // SETTLE=3 sub with in_valid held high and a different instruction queued
        preload3(2'd1, 8'h09);
        preload3(2'd2, 8'h03);
        if3.in_valid = 1'b1;
        if3.in_instr = mk(F_SUB, 2'd3, 2'd1, 2'd2);
        @(negedge clk);
        if3.in_instr = mk(F_XOR, 2'd0, 2'd1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s3 alu_func", {26'h0, if3.alu_func}, 32'h22);
            checkOutput("s3 alu_a", {24'h0, if3.alu_a}, 32'h09);
            checkOutput("s3 alu_b", {24'h0, if3.alu_b}, 32'h03);
            checkOutput("s3 in_ready", {31'h0, if3.in_ready}, 32'h0);
            checkOutput("s3 done early", {31'h0, if3.done}, 32'h0);
            @(negedge clk);
        end
        checkOutput("s3 done", {31'h0, if3.done}, 32'h1);
        checkOutput("s3 done_rd", {30'h0, if3.done_rd}, 32'h3);
        checkOutput("s3 done_value", {24'h0, if3.done_value}, 32'h06);
        checkOutput("s3 in_ready wb", {31'h0, if3.in_ready}, 32'h0);
        @(negedge clk);
        checkOutput("s3 done single", {31'h0, if3.done}, 32'h0);
        checkOutput("s3 in_ready idle", {31'h0, if3.in_ready}, 32'h1);
        checkOutput("s3 alu_func idle", {26'h0, if3.alu_func}, 32'h0);
        @(negedge clk);
        if3.in_valid = 1'b0;
        checkOutput("s3 xor alu_func", {26'h0, if3.alu_func}, 32'h26);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s3 xor done early", {31'h0, if3.done}, 32'h0);
            @(negedge clk);
        end
        checkOutput("s3 xor done", {31'h0, if3.done}, 32'h1);
        checkOutput("s3 xor done_rd", {30'h0, if3.done_rd}, 32'h0);
        checkOutput("s3 xor done_value", {24'h0, if3.done_value}, 32'h0A);
        @(negedge clk);
        checkReg3("s3 R3", 2'd3, 8'h06);
        checkReg3("s3 R0", 2'd0, 8'h0A);

        // Reset in the middle of HOLD
        applyStimulus(mk(F_ADD, 2'd3, 2'd2, 2'd2));
        checkOutput("abort pre alu_func", {26'h0, if1.alu_func}, 32'h20);
        rst1N = 1'b0;
        #1;
        checkOutput("abort alu_func", {26'h0, if1.alu_func}, 32'h0);
        checkOutput("abort alu_a", {24'h0, if1.alu_a}, 32'h0);
        checkOutput("abort alu_b", {24'h0, if1.alu_b}, 32'h0);
        checkOutput("abort done", {31'h0, if1.done}, 32'h0);
        checkOutput("abort in_ready", {31'h0, if1.in_ready}, 32'h1);
        @(negedge clk);
        checkOutput("abort done held", {31'h0, if1.done}, 32'h0);
        rst1N = 1'b1;
        @(negedge clk);
        checkOutput("abort done after", {31'h0, if1.done}, 32'h0);
        checkReg1("abort R3", 2'd3, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter SETTLE, default 1, range 1-15: number of cycles alu_func/alu_a/alu_b are held before alu_res is sampled.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  instruction word present.
REQ-005 in_ready  output  1  issuer can accept an instruction.
REQ-006 in_instr  input  16  [15:10] funct, [9:8] rd, [7:6] rs, [5:4] rt, [3:0] reserved (ignored).
REQ-007 alu_func  output  6  function code driven to the combinational ALU.
REQ-008 alu_a  output  8  operand A = R[rs].
REQ-009 alu_b  output  8  operand B = R[rt].
REQ-010 alu_res  input  8  ALU result, combinational from alu_func/alu_a/alu_b.
REQ-011 done  output  1  one-cycle pulse on register write-back.
REQ-012 done_rd  output  2  destination index, valid while done=1.
REQ-013 done_value  output  8  value written, valid while done=1.
REQ-014 err  output  1  one-cycle pulse on unsupported funct.
REQ-015 dbg_addr  input  2  register-file debug read address.
REQ-016 dbg_data  output  8  R[dbg_addr], combinational, reflects writes from the cycle after write-back.

Function
REQ-017 Internal register file: 4 x 8-bit registers R0-R3, all writable, no hard-wired zero.
REQ-018 Supported funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor; all others unsupported.
REQ-019 FSM states IDLE, HOLD, WB; in_ready=1 only in IDLE.
REQ-020 IDLE: on in_valid=1 the instruction is latched (handshake cycle T); unsupported funct -> err=1 at T+1, return to IDLE, no ALU drive, no write-back; supported -> HOLD.
REQ-021 HOLD: alu_func, alu_a, alu_b driven from latched funct and R[rs]/R[rt] read at T+1; held constant for SETTLE cycles; alu_res sampled at last HOLD edge; -> WB.
REQ-022 WB: R[rd] <= sampled result; done=1, done_rd=rd, done_value=result for exactly one cycle; -> IDLE.
REQ-023 Latency, supported op: done asserted at cycle T+1+SETTLE; next handshake possible the cycle after done.
REQ-024 Outside HOLD, alu_func=000000, alu_a=0, alu_b=0.
REQ-025 rd equal to rs or rt: operands use pre-write values; write-back overwrites afterward.
REQ-026 in_valid outside IDLE is ignored; in_instr is not required to remain stable after the handshake.
REQ-027 Arithmetic is the ALU's; issuer writes back alu_res bits unmodified (wrap-around modulo 256 is the ALU's result).
REQ-028 done and err never assert in the same cycle.

Reset
REQ-029 rst_n=0 forces immediately, independent of clk: state IDLE, R0-R3=0, done=0, err=0, done_rd=0, done_value=0, alu_* outputs=0.
REQ-030 in_ready=1 while held in reset-released IDLE; first handshake accepted on the first rising edge with rst_n=1 and in_valid=1.
REQ-031 Reset asserted in HOLD or WB aborts the instruction; no register write occurs; no done pulse.

Verification
REQ-032 Reset, then dbg_addr 0-3 -> dbg_data=00 for all; in_ready=1.
REQ-033 Preload via behavioural ALU: R1=05 (e.g. or of R0,R0 not usable -> bench uses add with forced alu_res=05, rd=1); then add rd=2 rs=1 rt=1, SETTLE=1 -> alu_func=100000, alu_a=05, alu_b=05 held 1 cycle, done at T+2 with done_rd=2, done_value=0A, R2=0A.
REQ-034 funct=000000 -> err pulse at T+1, no done, alu_* remain 0, all registers unchanged, in_ready=1 at T+1.
REQ-035 R1=FF, R2=01, add rd=1 rs=1 rt=2 -> done_value=00, R1=00 (wrap from ALU, operands taken pre-write).
REQ-036 SETTLE=3, sub issued, in_valid held high with different instr throughout -> alu_* stable 3 cycles, only one done, second instr accepted only after return to IDLE.
REQ-037 Assert rst_n=0 mid-HOLD -> outputs zero at once, no done, target register stays at 00.
